// File: rtl/pet_pkg.sv
// Shared PET loader definitions: state encoding, memory-map constants and file indices.
// Also holds the helper that picks one byte of a 16-bit pointer.
package pet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_FIN    = 3'd4,
    ST_ROM    = 3'd5
  } ldr_state_t;

  localparam logic [7:0]  PRG_IDX      = 8'h41;
  localparam logic [7:0]  ROM_IDX      = 8'h00;
  localparam logic [15:0] RAM_TOP_DEF  = 16'h8000;
  localparam logic [15:0] PTR_BASE_DEF = 16'h002A;
  localparam logic [15:0] ROM_MIN_DEF  = 16'h0400;
  localparam logic [24:0] ROM_LIMIT    = 25'h0008000;
  localparam logic [15:0] ROM_BASE     = 16'h8000;
  localparam logic [2:0]  FIN_LAST     = 3'd5;

  // Even pointer slots take the low byte, odd slots the high byte.
  function automatic logic [7:0] ptr_byte(input logic [15:0] p, input logic [2:0] idx);
    return idx[0] ? p[15:8] : p[7:0];
  endfunction

endpackage

// File: rtl/prg_loader.sv
// PRG/ROM download loader: strips the PRG header, streams payload into PET RAM,
// patches VARTAB/ARYTAB/STREND at the end, or relocates ROM images to $8000+.
module prg_loader
  import pet_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX = PRG_IDX,
  parameter logic [7:0]  ROM_INDEX = ROM_IDX,
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEF,
  parameter logic [15:0] PTR_BASE  = PTR_BASE_DEF,
  parameter logic [15:0] ROM_MIN   = ROM_MIN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data,
  output logic        dma_we,
  output logic        busy,
  output logic        overflow
);

  ldr_state_t  state_reg, state_next;
  logic [15:0] ptr_reg;
  logic        overflow_reg;
  logic        payload_seen_reg;
  logic [2:0]  fin_idx_reg;
  logic        fin_gap_reg;
  logic [15:0] dma_addr_reg;
  logic [7:0]  dma_data_reg;
  logic        dma_we_reg;

  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rom_in_window;

  assign rom_in_window = (ioctl_addr >= {9'd0, ROM_MIN}) && (ioctl_addr < ROM_LIMIT);

  // State register plus the datapath registers it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ptr_reg          <= '0;
      overflow_reg     <= 1'b0;
      payload_seen_reg <= 1'b0;
      fin_idx_reg      <= '0;
      fin_gap_reg      <= 1'b0;
      dma_addr_reg     <= '0;
      dma_data_reg     <= '0;
      dma_we_reg       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dma_we_reg <= wr_req;
      if (wr_req) begin
        dma_addr_reg <= wr_addr;
        dma_data_reg <= wr_data;
      end
      case (state_reg)
        ST_IDLE: begin
          fin_idx_reg      <= '0;
          fin_gap_reg      <= 1'b0;
          payload_seen_reg <= 1'b0;
          if (ioctl_download && ioctl_index == PRG_INDEX)
            overflow_reg <= 1'b0;
        end
        ST_HDR_LO: if (ioctl_download && ioctl_wr) ptr_reg[7:0]  <= ioctl_dout;
        ST_HDR_HI: if (ioctl_download && ioctl_wr) ptr_reg[15:8] <= ioctl_dout;
        // A strobe coinciding with the download drop is still a payload byte.
        ST_DATA: begin
          if (ioctl_wr) begin
            payload_seen_reg <= 1'b1;
            if (ptr_reg < RAM_TOP)
              ptr_reg <= ptr_reg + 16'd1;
            else
              overflow_reg <= 1'b1;
          end
        end
        ST_FIN: begin
          if (!fin_gap_reg) begin
            fin_gap_reg <= 1'b1;
          end else begin
            fin_gap_reg <= 1'b0;
            fin_idx_reg <= fin_idx_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ioctl_download) begin
          if (ioctl_index == PRG_INDEX)
            state_next = ST_HDR_LO;
          else if (ioctl_index == ROM_INDEX)
            state_next = ST_ROM;
        end
      end
      ST_HDR_LO: begin
        if (!ioctl_download)  state_next = ST_IDLE;
        else if (ioctl_wr)    state_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (!ioctl_download)  state_next = ST_IDLE;
        else if (ioctl_wr)    state_next = ST_DATA;
      end
      // A header-only file carries no program, so the pointers are left alone.
      ST_DATA: begin
        if (!ioctl_download)
          state_next = (payload_seen_reg || ioctl_wr) ? ST_FIN : ST_IDLE;
      end
      ST_FIN: begin
        if (fin_gap_reg && fin_idx_reg == FIN_LAST)
          state_next = ST_IDLE;
      end
      ST_ROM: begin
        if (!ioctl_download) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_reg)
      ST_DATA: begin
        if (ioctl_wr && ptr_reg < RAM_TOP) begin
          wr_req  = 1'b1;
          wr_addr = ptr_reg;
          wr_data = ioctl_dout;
        end
      end
      ST_FIN: begin
        if (!fin_gap_reg) begin
          wr_req  = 1'b1;
          wr_addr = PTR_BASE + {13'd0, fin_idx_reg};
          wr_data = ptr_byte(ptr_reg, fin_idx_reg);
        end
      end
      ST_ROM: begin
        if (ioctl_download && ioctl_wr && rom_in_window) begin
          wr_req  = 1'b1;
          wr_addr = ioctl_addr[15:0] + ROM_BASE;
          wr_data = ioctl_dout;
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign ioctl_wait = (state_reg == ST_FIN);
  assign dma_addr   = dma_addr_reg;
  assign dma_data   = dma_data_reg;
  assign dma_we     = dma_we_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: expected DMA writes are queued as stimulus is
// driven and matched (address, data and, for pointer writes, exact cycle) on dma_we.
module tb_prg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_we;
  logic        busy;
  logic        overflow;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  prg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_addr       (dma_addr),
    .dma_data       (dma_data),
    .dma_we         (dma_we),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every DMA strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (dma_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", {16'd0, dma_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("dma_addr", {16'd0, dma_addr}, {16'd0, e.addr});
        check_val("dma_data", {24'd0, dma_data}, {24'd0, e.data});
        if (e.at >= 0) check_val("dma_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d, input int at);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 64 && cyc < t; i++) tick();
    check_val("wait_bound", cyc, t);
  endtask

  task automatic push_ptrs(input int n, input logic [15:0] endp, input int count);
    for (int k = 0; k < count; k++)
      push(16'h002A + 16'(k), (k % 2 == 1) ? endp[15:8] : endp[7:0], n + 1 + 2 * k);
  endtask

  // Drop download now; it is sampled at edge n, pointers follow at n+1..n+11.
  task automatic end_prg(input logic [15:0] endp);
    int n;
    ioctl_download = 1'b0;
    n = cyc + 1;
    push_ptrs(n, endp, 6);
    wait_until(n + 11);
    check_val("fin_busy", busy, 1);
    check_val("fin_wait", ioctl_wait, 1);
    tick();
    check_val("end_busy", busy, 0);
    check_val("end_wait", ioctl_wait, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    tick();
    tick();
    check_val("rst_dma_we", dma_we, 0);
    check_val("rst_dma_addr", dma_addr, 0);
    check_val("rst_dma_data", dma_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_wait", ioctl_wait, 0);
    check_val("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // PRG 01 04 A9 00 60
    begin_dl(8'h41);
    send(0, 8'h01);
    send(1, 8'h04);
    push(16'h0401, 8'hA9, -1); send(2, 8'hA9);
    push(16'h0402, 8'h00, -1); send(3, 8'h00);
    push(16'h0403, 8'h60, -1); send(4, 8'h60);
    end_prg(16'h0404);
    check_val("t1_overflow", overflow, 0);
    check_val("t1_q_empty", exp_q.size(), 0);

    // Load at $7FFE, four payload bytes: two land, two are dropped.
    begin_dl(8'h41);
    send(0, 8'hFE);
    send(1, 8'h7F);
    push(16'h7FFE, 8'h11, -1); send(2, 8'h11);
    push(16'h7FFF, 8'h22, -1); send(3, 8'h22);
    send(4, 8'h33);
    send(5, 8'h44);
    check_val("t2_overflow_data", overflow, 1);
    end_prg(16'h8000);
    check_val("t2_overflow", overflow, 1);
    check_val("t2_q_empty", exp_q.size(), 0);

    // Header-only PRG: no writes, busy drops right after download end.
    begin_dl(8'h41);
    check_val("t3_ovf_cleared", overflow, 0);
    send(0, 8'h00);
    send(1, 8'h10);
    ioctl_download = 1'b0;
    tick();
    check_val("t3_busy", busy, 0);
    tick(); tick();
    check_val("t3_q_empty", exp_q.size(), 0);

    // ROM image: only offsets inside [$0400,$8000) are relocated.
    begin_dl(8'h00);
    check_val("t4_busy", busy, 1);
    send(25'h03FF, 8'h5A);
    push(16'h8400, 8'hC3, -1); send(25'h0400, 8'hC3);
    push(16'hFFFF, 8'h7E, -1); send(25'h7FFF, 8'h7E);
    ioctl_download = 1'b0;
    tick();
    check_val("t4_end_busy", busy, 0);
    tick(); tick();
    check_val("t4_overflow", overflow, 0);
    check_val("t4_q_empty", exp_q.size(), 0);

    // Last payload strobe together with the download drop.
    begin_dl(8'h41);
    send(0, 8'h00);
    send(1, 8'h10);
    push(16'h1000, 8'hAA, -1); send(2, 8'hAA);
    push(16'h1001, 8'hBB, -1);
    ioctl_addr = 3;
    ioctl_dout = 8'hBB;
    ioctl_wr = 1'b1;
    ioctl_download = 1'b0;
    n = cyc + 1;
    push_ptrs(n, 16'h1002, 6);
    tick();
    ioctl_wr = 1'b0;
    wait_until(n + 12);
    check_val("t5_busy", busy, 0);
    check_val("t5_q_empty", exp_q.size(), 0);

    // Reset during FIN at n+4: only the first two pointer writes happen.
    begin_dl(8'h41);
    send(0, 8'h00);
    send(1, 8'h05);
    push(16'h0500, 8'h11, -1); send(2, 8'h11);
    ioctl_download = 1'b0;
    n = cyc + 1;
    push_ptrs(n, 16'h0501, 2);
    wait_until(n + 3);
    reset = 1'b1;
    tick();
    check_val("t6_dma_we", dma_we, 0);
    check_val("t6_dma_addr", dma_addr, 0);
    check_val("t6_dma_data", dma_data, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_wait", ioctl_wait, 0);
    check_val("t6_overflow", overflow, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check_val("t6_q_empty", exp_q.size(), 0);

    // Unknown index (tape): fully ignored.
    begin_dl(8'h01);
    check_val("t7_busy0", busy, 0);
    send(0, 8'h01);
    send(1, 8'h04);
    send(2, 8'hEA);
    check_val("t7_busy1", busy, 0);
    ioctl_download = 1'b0;
    tick(); tick();
    check_val("t7_busy2", busy, 0);
    check_val("t7_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
